// File: rtl/entrada_teclado.sv
// Keypad debounce front end with single-cycle enable pulse and inactivity timer.
// Optional macro DIGITO_FILTRO_EN: reject key codes above 9.
module entrada_teclado #(
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       teclaValida,
  input  logic [3:0] teclaCodigo,
  input  logic       clear,
  output logic       enable,
  output logic [3:0] digito,
  output logic       tempoLimite
);

  typedef enum logic [1:0] {
    SOLTO,
    FILTRANDO,
    PRESSIONADO,
    LIBERANDO
  } estado_t;

`ifdef DIGITO_FILTRO_EN
  localparam bit FILTRO = 1'b1;
`else
  localparam bit FILTRO = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

  estado_t          estado, estadoNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] timer, timerNext;
  logic [3:0]       codigo, codigoNext;
  logic [3:0]       digitoNext;
  logic             enableNext, tempoNext;
  logic             invalido;

  assign invalido = FILTRO && (teclaCodigo > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= SOLTO;
      cnt         <= '0;
      timer       <= '0;
      codigo      <= 4'h0;
      digito      <= 4'h0;
      enable      <= 1'b0;
      tempoLimite <= 1'b0;
    end else begin
      estado      <= estadoNext;
      cnt         <= cntNext;
      timer       <= timerNext;
      codigo      <= codigoNext;
      digito      <= digitoNext;
      enable      <= enableNext;
      tempoLimite <= tempoNext;
    end
  end

  always_comb begin
    estadoNext = estado;
    cntNext    = cnt;
    codigoNext = codigo;
    digitoNext = digito;
    enableNext = 1'b0;
    unique case (estado)
      SOLTO: begin
        if (teclaValida) begin
          codigoNext = teclaCodigo;
          cntNext    = UM;
          estadoNext = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (!teclaValida) begin
          estadoNext = SOLTO;
        end else if (teclaCodigo != codigo) begin
          codigoNext = teclaCodigo;
          cntNext    = invalido ? '0 : UM;
        end else if (invalido) begin
          cntNext = '0;
        end else if (cnt == ULTIMO) begin
          estadoNext = PRESSIONADO;
          enableNext = 1'b1;
          digitoNext = codigo;
        end else begin
          cntNext = cnt + UM;
        end
      end
      PRESSIONADO: begin
        if (!teclaValida) begin
          cntNext    = UM;
          estadoNext = LIBERANDO;
        end
      end
      LIBERANDO: begin
        if (teclaValida) begin
          estadoNext = PRESSIONADO;
        end else if (cnt == ULTIMO) begin
          cntNext    = '0;
          estadoNext = SOLTO;
        end else begin
          cntNext = cnt + UM;
        end
      end
      default: estadoNext = SOLTO;
    endcase
  end

  // Timer restarts on the registered enable, so it counts from the pulse cycle.
  always_comb begin
    timerNext = '0;
    tempoNext = 1'b0;
    if (!clear && !enable) begin
      timerNext = (timer == LIMITE) ? timer : timer + UM;
      tempoNext = (timerNext == LIMITE);
    end
  end

endmodule

// File: tb/tb_entrada_teclado.sv
// Self-checking bench for entrada_teclado against a sample-window reference model.
// Honours DIGITO_FILTRO_EN in the model when the macro is defined.
module tb_entrada_teclado;

  localparam int DEB = 4;
  localparam int TMO = 20;

`ifdef DIGITO_FILTRO_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       teclaValida = 1'b0;
  logic [3:0] teclaCodigo = 4'h0;
  logic       clear = 1'b1;
  logic       enable;
  logic [3:0] digito;
  logic       tempoLimite;

  always #5 clk = ~clk;

  entrada_teclado #(
    .DEBOUNCE(DEB),
    .TIMEOUT (TMO),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .teclaValida(teclaValida),
    .teclaCodigo(teclaCodigo),
    .clear      (clear),
    .enable     (enable),
    .digito     (digito),
    .tempoLimite(tempoLimite)
  );

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;
  int lastZero = 0;
  int pulses = 0;
  bit held = 1'b0;
  bit expEn = 1'b0;
  bit expTL = 1'b0;
  logic [3:0] expDig = 4'h0;
  bit hv[$];
  logic [3:0] hc[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h",
             tag, edgeCnt, got, exp);
    end
  endtask

  function automatic bit windowPress();
    if (hv.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (!hv[i] || hc[i] != hc[0]) return 1'b0;
    if (FILT && hc[0] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit windowLow();
    if (hv.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (hv[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit v, input logic [3:0] c,
                      input bit clr);
    teclaValida = v;
    teclaCodigo = c;
    clear = clr;
    @(posedge clk);
    edgeCnt++;
    hv.push_back(v);
    hc.push_back(c);
    if (hv.size() > DEB) begin
      void'(hv.pop_front());
      void'(hc.pop_front());
    end
    if (clr || expEn) lastZero = edgeCnt;
    expTL = (edgeCnt - lastZero) >= TMO;
    expEn = 1'b0;
    if (!held) begin
      if (windowPress()) begin
        expEn = 1'b1;
        expDig = hc[DEB-1];
        held = 1'b1;
      end
    end else if (windowLow()) begin
      held = 1'b0;
    end
    #1;
    check("enable", enable, expEn);
    check("digito", digito, expDig);
    check("tempoLimite", tempoLimite, expTL);
    if (enable) pulses++;
  endtask

  task automatic hold(input bit v, input logic [3:0] c,
                      input bit clr, input int n);
    for (int i = 0; i < n; i++) step(v, c, clr);
  endtask

  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_enable", enable, 0);
    check("rst_digito", digito, 0);
    check("rst_tempo", tempoLimite, 0);
    hv.delete();
    hc.delete();
    held = 1'b0;
    expEn = 1'b0;
    expDig = 4'h0;
    expTL = 1'b0;
    lastZero = edgeCnt;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("init_enable", enable, 0);
    check("init_digito", digito, 0);
    check("init_tempo", tempoLimite, 0);
    #8;
    rst_n = 1'b1;
    hold(0, 0, 1, 3);

    pulses = 0;
    hold(1, 5, 0, 10);
    hold(0, 5, 0, 10);
    check("s1_pulses", pulses, 1);
    check("s1_digito", digito, 5);

    pulses = 0;
    step(1, 3, 0);
    step(1, 3, 0);
    step(0, 3, 0);
    check("s2_early", pulses, 0);
    hold(1, 3, 0, 4);
    check("s2_pulses", pulses, 1);
    hold(0, 3, 0, 6);

    pulses = 0;
    hold(1, 2, 0, 2);
    hold(1, 7, 0, 4);
    check("s3_pulses", pulses, 1);
    check("s3_digito", digito, 7);
    hold(0, 7, 0, 6);

    pulses = 0;
    hold(1, 9, 0, 5);
    hold(0, 9, 0, 2);
    hold(1, 9, 0, 2);
    hold(0, 9, 0, 4);
    check("s4_pulses", pulses, 1);
    hold(1, 1, 0, 4);
    check("s4_repress", pulses, 2);
    hold(0, 1, 0, 6);

    hold(1, 6, 0, 4);
    hold(0, 6, 0, 30);
    check("s5_tempo", tempoLimite, 1);
    step(0, 6, 1);
    check("s5_clear", tempoLimite, 0);
    hold(0, 6, 0, 25);
    hold(1, 8, 0, 5);
    check("s5_restart", tempoLimite, 0);
    hold(0, 8, 0, 6);

    pulses = 0;
    hold(1, 5, 0, 2);
    pulseReset();
    hold(1, 5, 0, 2);
    check("s6_nopulse", pulses, 0);
    hold(1, 5, 0, 4);
    check("s6_fresh", pulses, 1);
    hold(0, 5, 0, 6);

    pulses = 0;
    hold(1, 12, 0, 10);
    hold(0, 12, 0, 6);
    check("s6_filter", pulses, FILT ? 0 : 1);

    for (int r = 0; r < 80; r++) begin
      bit v;
      bit clr;
      logic [3:0] c;
      int n;
      v = ($urandom_range(0, 2) != 0);
      c = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0);
      n = $urandom_range(1, 8);
      hold(v, c, clr, n);
      if ($urandom_range(0, 29) == 0) pulseReset();
    end
    hold(0, 0, 0, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
